// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - SZ_* request size encodings
//   - lsu_state_t: LSU sub-word store FSM states
//   - WORD_ALIGN_MASK: clears the byte lane bits of a byte address
//   - size_aligned(): alignment legality of a request
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } lsu_state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Size 11 is never legal; half needs an even address, word a multiple of 4.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bus bundle between the EX/MEM pipeline, the LSU and the data memory.
//   req_*      : memory op from EX/MEM (held stable while stall=1)
//   stall      : freeze upstream
//   ld_valid/ld_data/misalign : registered results to MEM/WB
//   mem_*      : word-wide data memory port, mem_dout is combinational read data
// modport slave  : the LSU
// modport master : pipeline + memory side
interface mem_lsu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              misalign;
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output stall, ld_valid, ld_data, misalign, mem_cs, mem_we, mem_oe, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  stall, ld_valid, ld_data, misalign, mem_cs, mem_we, mem_oe, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// Combinational byte-lane steering for the LSU.
//   lane, size, uns : request lane (addr[1:0]), size code, zero-extend select
//   rdata           : word read from memory
//   wdata           : store data, value in low bits
//   ld_word         : extracted and extended load result
//   st_word         : rdata with the addressed lane replaced by wdata
module lsu_lane_align
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] st_word
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] size_mask;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SZ_BYTE: ld_word = uns ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                   : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_word = uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                   : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            default: ld_word = rdata;
        endcase

        case (size)
            SZ_BYTE: size_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
            SZ_HALF: size_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            default: size_mask = '1;
        endcase
        lane_mask = size_mask << {lane, 3'b000};
        st_word   = (rdata & ~lane_mask) | ((wdata << {lane, 3'b000}) & lane_mask);
    end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-wide data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_lsu_if.slave (request, stall, load result, memory port)
// Byte/half stores are a read (IDLE, stall=1) followed by a write of the
// merged word (RMW_WR); everything else completes in a single cycle.
module mem_lsu
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_lsu_if.slave bus
);
    lsu_state_t        state;
    lsu_state_t        state_nx;
    logic [DATA_W-1:0] merge_buf;
    logic              ld_valid_q;
    logic [DATA_W-1:0] ld_data_q;
    logic              misalign_q;

    logic [1:0]        lane;
    logic              aligned;
    logic              idle_req;
    logic              is_load;
    logic              is_wst;
    logic              is_sst;
    logic              is_bad;
    logic              in_wr;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] st_word;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane    (lane),
        .size    (bus.req_size),
        .uns     (bus.req_unsigned),
        .rdata   (bus.mem_dout),
        .wdata   (bus.req_wdata),
        .ld_word (ld_word),
        .st_word (st_word)
    );

    // Decode is gated by rst_n so the memory port and stall are quiet
    // for the whole reset, not just after the state register clears.
    always_comb begin
        lane      = bus.req_addr[1:0];
        aligned   = size_aligned(bus.req_size, lane);
        word_addr = bus.req_addr & ~(ADDR_W'(~WORD_ALIGN_MASK));
        idle_req  = rst_n && (state == ST_IDLE) && bus.req_valid;
        in_wr     = rst_n && (state == ST_RMW_WR);
        is_load   = idle_req && aligned && !bus.req_we;
        is_wst    = idle_req && aligned && bus.req_we && (bus.req_size == SZ_WORD);
        is_sst    = idle_req && aligned && bus.req_we && (bus.req_size != SZ_WORD);
        is_bad    = idle_req && !aligned;

        bus.mem_cs   = is_load || is_wst || is_sst || in_wr;
        bus.mem_oe   = is_load || is_sst;
        bus.mem_we   = is_wst || in_wr;
        bus.mem_addr = bus.mem_cs ? word_addr : '0;
        bus.mem_din  = in_wr ? merge_buf : (is_wst ? bus.req_wdata : '0);
        bus.stall    = is_sst;
        state_nx     = is_sst ? ST_RMW_WR : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            merge_buf  <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nx;
            ld_valid_q <= is_load;
            misalign_q <= is_bad;
            if (is_sst)
                merge_buf <= st_word;
            if (is_load)
                ld_data_q <= ld_word;
        end
    end

    assign bus.ld_valid = ld_valid_q;
    assign bus.ld_data  = ld_data_q;
    assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte-addressed memory model, 256 bytes, combinational read.
    logic [7:0] mem [256];
    int unsigned wr_cnt = 0;
    int unsigned stall_seen = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always_comb begin
        bus.mem_dout = {mem[{bus.mem_addr[7:2], 2'd3}], mem[{bus.mem_addr[7:2], 2'd2}],
                        mem[{bus.mem_addr[7:2], 2'd1}], mem[{bus.mem_addr[7:2], 2'd0}]};
    end

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) begin
            mem[{bus.mem_addr[7:2], 2'd0}] <= bus.mem_din[7:0];
            mem[{bus.mem_addr[7:2], 2'd1}] <= bus.mem_din[15:8];
            mem[{bus.mem_addr[7:2], 2'd2}] <= bus.mem_din[23:16];
            mem[{bus.mem_addr[7:2], 2'd3}] <= bus.mem_din[31:24];
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}], mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
    endfunction

    task automatic poke_word(input logic [7:0] a, input logic [31:0] v);
        mem[{a[7:2], 2'd0}] = v[7:0];
        mem[{a[7:2], 2'd1}] = v[15:8];
        mem[{a[7:2], 2'd2}] = v[23:16];
        mem[{a[7:2], 2'd3}] = v[31:24];
    endtask

    // Scoreboard: load results popped when the DUT presents ld_valid.
    always begin
        @(posedge clk);
        #1;
        if (bus.ld_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ld_valid_unexpected actual 1 required 0");
            end else begin
                check("ld_data", bus.ld_data, exp_q.pop_front());
            end
        end
        if (bus.mem_oe && bus.mem_we) begin
            errors++;
            $display("FAIL oe_we_exclusive actual 11 required not both");
        end
    end

    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_mis, input logic exp_stall, input logic [31:0] exp_ld);
        logic is_ld;
        is_ld = !we && !exp_mis;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        if (is_ld)
            exp_q.push_back(exp_ld);
        #1;
        if (bus.stall) stall_seen++;
        check("stall", 32'(bus.stall), 32'(exp_stall));
        check("mem_cs", 32'(bus.mem_cs), 32'(!exp_mis));
        if (we && !exp_mis && !exp_stall) begin
            check("sw_mem_we", 32'(bus.mem_we), 32'd1);
            check("sw_mem_din", bus.mem_din, wd);
        end
        if (exp_stall) begin
            @(negedge clk);
            #1;
            if (bus.stall) stall_seen++;
            check("rmw_stall", 32'(bus.stall), 32'd0);
            check("rmw_mem_we", 32'(bus.mem_we), 32'd1);
        end
        @(posedge clk);
        #1;
        check("misalign", 32'(bus.misalign), 32'(exp_mis));
        check("ld_valid", 32'(bus.ld_valid), 32'(is_ld));
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    typedef struct {
        logic        poke;
        logic [7:0]  poke_addr;
        logic [7:0]  poke_val;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        mis;
        logic        stl;
        logic [31:0] ld;
    } vec_t;

    vec_t vt [18];
    int unsigned wr0;
    int unsigned st0;

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        poke_word(8'h10, 32'h12345678);

        vt[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h12345678};
        vt[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h00000012};
        vt[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, 32'h00001234};
        vt[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h00000078};
        vt[4]  = '{1'b1, 8'h11, 8'h86, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 32'hFFFFFF86};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 32'h00000086};
        vt[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hFFFF8678};
        vt[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h00008678};
        vt[8]  = '{1'b1, 8'h11, 8'h56, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hFFFFFFAB, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h12AB5678};
        vt[10] = '{1'b0, 8'h00, 8'h00, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h1111, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b0, 8'h00, 8'h00, 1'b1, SZ_WORD, 1'b0, 32'h12, 32'h22222222, 1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_ILL,  1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[14] = '{1'b0, 8'h00, 8'h00, 1'b1, SZ_ILL,  1'b0, 32'h10, 32'h33333333, 1'b1, 1'b0, 32'h0};
        vt[15] = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h12AB5678};
        vt[16] = '{1'b0, 8'h00, 8'h00, 1'b1, SZ_WORD, 1'b0, 32'h18, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[17] = '{1'b0, 8'h00, 8'h00, 1'b0, SZ_HALF, 1'b1, 32'h1A, 32'h0, 1'b0, 1'b0, 32'h0000DEAD};

        // Reset state, with a sub-word store presented during reset.
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
        check("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
        check("rst_ld_data", bus.ld_data, 32'd0);
        check("rst_misalign", 32'(bus.misalign), 32'd0);
        check("rst_no_write", wr_cnt, 32'd0);
        go_idle();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vt[i].poke) mem[vt[i].poke_addr] = vt[i].poke_val;
            if (i == 10) wr0 = wr_cnt;
            do_op(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
                  vt[i].mis, vt[i].stl, vt[i].ld);
            if (i == 14) check("misalign_no_write", wr_cnt, wr0);
        end
        go_idle();
        check("word_10", word_at(8'h10), 32'h12AB5678);
        check("word_18", word_at(8'h18), 32'hDEADBEEF);

        // Back-to-back sub-word stores with the request held between them.
        st0 = stall_seen;
        do_op(1'b1, SZ_HALF, 1'b0, 32'h20, 32'h0000BEEF, 1'b0, 1'b1, 32'h0);
        do_op(1'b1, SZ_BYTE, 1'b0, 32'h23, 32'h000000CA, 1'b0, 1'b1, 32'h0);
        check("b2b_stalls", stall_seen - st0, 32'd2);
        do_op(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'hCA00BEEF);
        go_idle();
        check("word_20", word_at(8'h20), 32'hCA00BEEF);

        // Reset asserted while in RMW_WR: the store is dropped.
        poke_word(8'h30, 32'h11223344);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h55;
        #1;
        check("rr_stall", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        check("rr_in_wr", 32'(bus.mem_we), 32'd1);
        wr0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        check("rr_mem_we", 32'(bus.mem_we), 32'd0);
        check("rr_mem_cs", 32'(bus.mem_cs), 32'd0);
        check("rr_stall0", 32'(bus.stall), 32'd0);
        check("rr_ld_data", bus.ld_data, 32'd0);
        check("rr_ld_valid", 32'(bus.ld_valid), 32'd0);
        check("rr_misalign", 32'(bus.misalign), 32'd0);
        @(posedge clk);
        #1;
        check("rr_no_write", wr_cnt, wr0);
        check("rr_word", word_at(8'h30), 32'h11223344);
        check("rr_state", 32'(dut.state), 32'(ST_IDLE));
        check("rr_merge_buf", dut.merge_buf, 32'd0);
        go_idle();
        rst_n = 1'b1;
        do_op(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h11223344);
        go_idle();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
